// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-way round-robin grant arbiter.
// Optional macro RR_ARB_TIMEOUT_EN (used by rr_grant_arbiter_16) enables the
// maximum-hold timeout; MAX_HOLD_DEF is its default hold limit.
package rr_arb_pkg;

    localparam int N_REQ        = 16;
    localparam int IDX_W        = 4;
    localparam int MAX_HOLD_DEF = 8;

    // Arbiter control state: idle (no grantee) or a grant in progress.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : rr_arb_pkg

// File: rtl/onehot_dec4.sv
// Combinational 4-to-16 one-hot decoder. The output is forced to zero when
// the enable is low, so the result is always one-hot or all zeros.
module onehot_dec4
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_onehot
);

    // Expand the binary index to a single set bit, gated by the enable.
    always_comb begin
        o_onehot = 16'h0000;
        if (i_en) begin
            o_onehot = 16'h0001 << i_idx;
        end else begin
            o_onehot = 16'h0000;
        end
    end

endmodule : onehot_dec4

// File: rtl/rr_grant_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// The winner index is registered; the one-hot grant is decoded from that
// registered index and gated by the registered valid flag, so an
// asynchronous reset removes the grant immediately.
// rst_n is expected to be released synchronously to clk by the reset tree.
//
// Optional feature, macro RR_ARB_TIMEOUT_EN: a requester may hold the grant
// for at most MAX_HOLD consecutive cycles (2..256). When the limit is hit
// the grant is revoked, rotation proceeds as on a normal release, and
// timeout_pulse is raised for one cycle. Without the macro the grant is
// held until the request drops and timeout_pulse is tied low.
module rr_grant_arbiter_16
    import rr_arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_pulse
);

    // Pick the first requester after 'base' in circular order. The base
    // itself is examined last, so the previous grantee only wins when it is
    // the sole requester. Returns 'base' when no bit is set; callers only
    // use the result when req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [IDX_W-1:0] base,
        input logic [N_REQ-1:0] r
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = base;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = base + IDX_W'(k);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_last_idx;
    logic             r_grant_valid;
    logic             r_timeout_pulse;

    logic             w_any_req;
    logic             w_own_req;
    logic             w_timeout_fire;
    logic             w_release;
    logic [IDX_W-1:0] w_pick_base;
    logic [IDX_W-1:0] w_winner;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold_cnt;

    // Timeout fires on the cycle the hold count reaches its last allowed
    // value while the grantee is still requesting.
    always_comb begin
        w_timeout_fire = 1'b0;
        if ((r_state == GRANT) && w_own_req && (r_hold_cnt == HOLD_LAST)) begin
            w_timeout_fire = 1'b1;
        end else begin
            w_timeout_fire = 1'b0;
        end
    end

    // Hold counter: zero on every fresh grant, saturating count while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else if ((r_state == GRANT) && !w_release) begin
            if (r_hold_cnt != 8'hFF) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else begin
                r_hold_cnt <= r_hold_cnt;
            end
        end else begin
            r_hold_cnt <= 8'd0;
        end
    end
`else
    // Without the timeout feature a grant can only end by request drop.
    always_comb begin
        w_timeout_fire = 1'b0;
    end
`endif

    // Request summary, release detection and winner search. While a grant
    // is active the search starts after the current grantee; when idle it
    // starts after the last grantee.
    always_comb begin
        w_any_req   = |req;
        w_own_req   = req[r_grant_idx];
        w_release   = 1'b0;
        w_pick_base = r_last_idx;
        if (r_state == GRANT) begin
            w_release   = !w_own_req || w_timeout_fire;
            w_pick_base = r_grant_idx;
        end else begin
            w_release   = 1'b0;
            w_pick_base = r_last_idx;
        end
        w_winner = rr_pick(w_pick_base, req);
    end

    // Arbitration FSM with registered grant index, valid and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_grant_idx     <= 4'd0;
            r_last_idx      <= 4'd15;
            r_grant_valid   <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout_fire;
            case (r_state)
                IDLE: begin
                    if (en && w_any_req) begin
                        r_state       <= GRANT;
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                    end else begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last_idx <= r_grant_idx;
                        if (en && w_any_req) begin
                            r_state       <= GRANT;
                            r_grant_idx   <= w_winner;
                            r_grant_valid <= 1'b1;
                        end else begin
                            r_state       <= IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end else begin
                        r_state       <= GRANT;
                        r_grant_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    onehot_dec4 u_dec (
        .i_idx    (r_grant_idx),
        .i_en     (r_grant_valid),
        .o_onehot (grant)
    );

    assign grant_idx     = r_grant_idx;
    assign grant_valid   = r_grant_valid;
    assign timeout_pulse = r_timeout_pulse;

endmodule : rr_grant_arbiter_16

// File: tb/tb_rr_grant_arbiter_16.sv
// Self-checking bench for rr_grant_arbiter_16: directed steps plus random
// traffic, checked against a cycle-level model of the round-robin rules.
// Define RR_ARB_TIMEOUT_EN for both bench and RTL to cover the timeout.
module tb_rr_grant_arbiter_16;

    localparam int MAX_HOLD = 8;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_valid;
    bit m_tp;
    int m_idx;
    int m_last;
    int m_hold;

    rr_grant_arbiter_16 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req           (req),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic int rr_next(int from, logic [15:0] r);
        for (int k = 1; k <= 16; k++) begin
            if (r[(from + k) % 16]) return (from + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_tp    = 1'b0;
        m_idx   = 0;
        m_last  = 15;
        m_hold  = 0;
    endtask

    task automatic model_step();
        bit rel_drop;
        bit rel_to;
        if (!m_valid) begin
            m_tp = 1'b0;
            if (en && req != 16'h0) begin
                m_idx   = rr_next(m_last, req);
                m_valid = 1'b1;
                m_hold  = 0;
            end
        end else begin
            rel_drop = !req[m_idx];
            rel_to   = TO_EN && req[m_idx] && (m_hold == MAX_HOLD - 1);
            m_tp     = rel_to;
            if (rel_drop || rel_to) begin
                m_last = m_idx;
                if (en && req != 16'h0) begin
                    m_idx  = rr_next(m_idx, req);
                    m_hold = 0;
                end else begin
                    m_valid = 1'b0;
                    m_hold  = 0;
                end
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] exp_grant;
        exp_grant = m_valid ? (16'h0001 << m_idx) : 16'h0000;
        chk("grant_valid", 32'(grant_valid), 32'(m_valid));
        chk("grant", 32'(grant), 32'(exp_grant));
        if (m_valid) chk("grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
    endtask

    task automatic step(input logic e, input logic [15:0] r);
        en  = e;
        req = r;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0000;
        model_reset();
        #1;
        check_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        logic        e;

        // Reset and idle
        do_reset();
        step(1'b1, 16'h0000);
        step(1'b1, 16'h0000);

        // Single requester
        step(1'b1, 16'h0010);
        chk("single_grant", 32'(grant), 32'h0010);
        chk("single_idx", 32'(grant_idx), 32'd4);
        step(1'b1, 16'h0000);
        chk("single_drop", 32'(grant), 32'h0000);

        // Rotation with all requesting, each grantee dropping for one cycle
        do_reset();
        step(1'b1, 16'hFFFF);
        chk("rotation_first", 32'(grant_idx), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 16'hFFFF & ~(16'h0001 << k));
            chk("rotation_idx", 32'(grant_idx), 32'((k + 1) % 16));
            chk("rotation_nogap", 32'(grant_valid), 32'd1);
        end
        step(1'b1, 16'h0000);

        // Wrap priority after grantee 14
        step(1'b1, 16'h4000);
        chk("wrap_14", 32'(grant_idx), 32'd14);
        step(1'b1, 16'h0000);
        step(1'b1, 16'h8003);
        chk("wrap_15", 32'(grant_idx), 32'd15);
        step(1'b1, 16'h0003);
        chk("wrap_0", 32'(grant_idx), 32'd0);
        step(1'b1, 16'h8002);
        chk("wrap_1", 32'(grant_idx), 32'd1);
        step(1'b1, 16'h0000);

        // Enable gating
        repeat (3) step(1'b0, 16'h0100);
        chk("en_block", 32'(grant), 32'h0000);
        step(1'b1, 16'h0100);
        chk("en_grant", 32'(grant), 32'h0100);
        repeat (4) step(1'b0, 16'h0100);
        chk("en_hold", 32'(grant), 32'h0100);
        step(1'b0, 16'h0000);
        chk("en_release", 32'(grant), 32'h0000);

        // Reset mid-grant drops the grant at once, priority back to 0
        step(1'b1, 16'h0400);
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0000);
        chk("async_rst_valid", 32'(grant_valid), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'hFFFF);
        chk("rst_priority", 32'(grant_idx), 32'd0);
        step(1'b1, 16'h0000);

`ifdef RR_ARB_TIMEOUT_EN
        // Timeout: bit 0 held for MAX_HOLD cycles, then handed to bit 2
        do_reset();
        for (int k = 0; k < MAX_HOLD; k++) begin
            step(1'b1, 16'h0005);
            chk("to_hold", 32'(grant), 32'h0001);
        end
        step(1'b1, 16'h0005);
        chk("to_pulse", 32'(timeout_pulse), 32'd1);
        chk("to_next", 32'(grant), 32'h0004);
        step(1'b1, 16'h0001);
        for (int k = 0; k < MAX_HOLD - 1; k++) step(1'b1, 16'h0001);
        step(1'b1, 16'h0001);
        chk("to_sole_pulse", 32'(timeout_pulse), 32'd1);
        chk("to_sole_regrant", 32'(grant), 32'h0001);
        step(1'b1, 16'h0000);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            e = ($urandom_range(0, 7) != 0);
            r = 16'($urandom & $urandom);
            if (m_valid && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
            if ($urandom_range(0, 9) == 0) r = 16'h0000;
            step(e, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rr_grant_arbiter_16

// File: doc/rr_grant_arbiter_16.md
Name: rr_grant_arbiter_16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Selects a winner index (4 bits) and expands it to a one-hot 16-bit grant through a 4-to-16 decoder stage.
- Sits between requesting agents and the shared resource. The one-hot grant drives resource select/mux enables directly.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 (IDX_W = 4).
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant when the timeout feature is compiled in; legal range 2..256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants but does not revoke the current grant.
- req  input  16  request vector; bit i = requester i wants the resource.
- grant  output  16  one-hot grant, or all zeros when idle.
- grant_idx  output  4  binary index of the current grantee; valid only when grant_valid=1.
- grant_valid  output  1  a grant is active.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout; tied 0 without the feature.

Behaviour:
- Reset (async assert, sync release): grant=16'h0, grant_idx=0, grant_valid=0, timeout_pulse=0, state=IDLE, hold_cnt=0.
- Reset sets internal last_idx=15, so requester 0 has top priority after reset.
- States: IDLE, GRANT.
- Winner search: first set bit of req scanning last_idx+1, last_idx+2, … with mod-16 wrap. The previous grantee has lowest priority and wins only if it is the sole requester.
- IDLE:
  - If en=1 and req!=0: register winner; next cycle state=GRANT, grant_valid=1, grant=1<<winner, hold_cnt=0.
  - Latency from req assertion to grant is exactly 1 cycle.
- GRANT:
  - grant stays constant while req[grant_idx]=1 and no timeout occurs.
  - hold_cnt increments each cycle, saturating.
- Release condition: req[grant_idx]=0, or a timeout (feature on).
- Release cycle:
  - last_idx<=grant_idx.
  - If en=1 and any other eligible request exists, the next winner (search from grant_idx+1) is granted on the next cycle with no idle gap.
  - Otherwise go to IDLE with grant=0 and grant_valid=0 on the next cycle.
- Requests arriving mid-grant are not pre-empted. They are evaluated only at release.
- en=0 during GRANT: the current grant runs to release, then the block enters IDLE.
- req bits are level-sensitive and not latched. A request dropped before it is served is forgotten.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (grant_valid ? 1<<grant_idx : 0).
- Reset asserted mid-grant: grant drops to 0 immediately (asynchronously) and priority returns to requester 0.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt reaches MAX_HOLD-1 with req[grant_idx] still 1, the grant is revoked at that cycle's release.
  - timeout_pulse=1 on the first cycle after revocation.
  - Rotation proceeds as on a normal release. If the timed-out requester is the sole requester, it is re-granted on the next cycle with hold_cnt reset to 0.
- Undefined:
  - No hold_cnt logic; the grant is held until the request drops.
  - timeout_pulse is tied to 0.

Decomposition:
- Package rr_arb_pkg holds:
  - localparams N_REQ=16 and IDX_W=4;
  - state typedef (IDLE, GRANT);
  - default MAX_HOLD.
- One sub-module, onehot_dec4: purely combinational 4-to-16 decoder used to form grant from the registered grant_idx and gated by grant_valid.
- Winner search and FSM live in the top module.

Test Plan:
- Reset/idle: assert rst_n=0 mid-grant → grant=0 and grant_valid=0 immediately. After release with req=0, outputs stay 0.
- Single requester: req=16'h0010 → 1 cycle later grant=16'h0010, grant_idx=4. Drop req → next cycle grant=0.
- Rotation: req=16'hFFFF held; each grantee drops its req bit for one cycle on grant → grant_idx sequence 0,1,2,…,15,0 with no idle cycles between grants.
- Wrap priority: last grantee 14, then req=16'h8003 → next grant_idx=15, then 0, then 1.
- Enable: en=0 with req=16'h0100 → grant stays 0. Raise en → grant=16'h0100 one cycle later. Drop en mid-grant → grant held until req[8] drops.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=8): req=16'h0005 held → grant bit 0 for 8 cycles, then timeout_pulse=1 and grant=16'h0004. With req=16'h0001 alone → bit 0 re-granted after the pulse.
